// File: rtl/arbitro_pkg.sv
// Shared definitions for the weighted-round-robin FIFO arbiter.
// Word layout: [W-1:W-2] class, [W-3 -: DEST_W] destination, remainder payload.
package arbitro_pkg;

    localparam int N_CH_DEF      = 4;
    localparam int WORD_SIZE_DEF = 12;
    localparam int WEIGHT_W_DEF  = 3;
    localparam int DEST_W_DEF    = $clog2(N_CH_DEF);

    localparam int CLASS_MSB = WORD_SIZE_DEF - 1;
    localparam int DEST_MSB  = WORD_SIZE_DEF - 3;

    function automatic logic [DEST_W_DEF-1:0] dest_of(input logic [WORD_SIZE_DEF-1:0] word);
        return word[DEST_MSB -: DEST_W_DEF];
    endfunction

endpackage

// File: rtl/arbitro_rr_pick.sv
// Rotating-priority first-one search: returns the first set request at or after start_i, wrapping.
// N must be a power of two so that index arithmetic wraps naturally.
module arbitro_rr_pick #(
    parameter  int N  = 4,
    localparam int DW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [DW-1:0] start_i,
    output logic          found_o,
    output logic [DW-1:0] idx_o
);

    logic [DW-1:0] cand;

    // Walk from the farthest offset back to start so the nearest hit is written last.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = start_i + DW'(k);
            if (req_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/arbitro_wrr.sv
// Weighted-round-robin / strict-priority arbiter from N_CH ingress FIFOs to N_CH egress FIFOs.
// One combinational pop per cycle; the popped word is pushed to its destination one cycle later.
module arbitro_wrr
    import arbitro_pkg::*;
#(
    parameter int N_CH      = N_CH_DEF,
    parameter int WORD_SIZE = WORD_SIZE_DEF,
    parameter int WEIGHT_W  = WEIGHT_W_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      mode,
    input  logic [N_CH*WEIGHT_W-1:0]  weights,
    input  logic [N_CH-1:0]           in_empty,
    input  logic [N_CH*WORD_SIZE-1:0] in_data,
    output logic [N_CH-1:0]           in_pop,
    input  logic [N_CH-1:0]           out_almost_full,
    output logic [N_CH-1:0]           out_push,
    output logic [WORD_SIZE-1:0]      out_data,
    output logic                      idle
);

    localparam int DEST_W = $clog2(N_CH);

    logic [N_CH-1:0][WORD_SIZE-1:0] head;
    logic [N_CH-1:0][WEIGHT_W-1:0]  wgt;
    logic [N_CH-1:0][DEST_W-1:0]    dst;
    logic [N_CH-1:0]                elig;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign head[i] = in_data[i*WORD_SIZE +: WORD_SIZE];
        assign wgt[i]  = weights[i*WEIGHT_W +: WEIGHT_W];
        assign dst[i]  = head[i][WORD_SIZE-3 -: DEST_W];
        assign elig[i] = !in_empty[i] && !out_almost_full[dst[i]] && (wgt[i] != '0);
    end

    logic [DEST_W-1:0]   cur_q, cur_d;
    logic [WEIGHT_W-1:0] credit_q, credit_d;
    logic [N_CH-1:0]     push_q;
    logic [WORD_SIZE-1:0] data_q;
    logic                idle_q;

    logic                w_found, p_found;
    logic [DEST_W-1:0]   w_idx, p_idx;
    logic [DEST_W-1:0]   cur_nxt;

    assign cur_nxt = cur_q + DEST_W'(1);

    arbitro_rr_pick #(.N(N_CH)) u_wrr_pick (
        .req_i   (elig),
        .start_i (cur_nxt),
        .found_o (w_found),
        .idx_o   (w_idx)
    );

    arbitro_rr_pick #(.N(N_CH)) u_pri_pick (
        .req_i   (elig),
        .start_i ('0),
        .found_o (p_found),
        .idx_o   (p_idx)
    );

    logic                stay;
    logic                gnt_vld;
    logic [DEST_W-1:0]   gnt;
    logic [WEIGHT_W-1:0] base, credit_new;

    // Staying on cur requires unused credit; a weight lowered under credit ends the burst.
    assign stay = elig[cur_q] && (credit_q < wgt[cur_q]);

    always_comb begin
        gnt_vld = 1'b0;
        gnt     = '0;
        base    = '0;
        if (mode) begin
            gnt_vld = p_found;
            gnt     = p_idx;
        end else if (stay) begin
            gnt_vld = 1'b1;
            gnt     = cur_q;
            base    = credit_q;
        end else begin
            gnt_vld = w_found;
            gnt     = w_idx;
        end
        gnt_vld    = gnt_vld & reset;
        credit_new = base + WEIGHT_W'(1);

        in_pop = '0;
        if (gnt_vld) in_pop[gnt] = 1'b1;

        cur_d    = cur_q;
        credit_d = credit_q;
        if (gnt_vld && !mode) begin
            if (credit_new >= wgt[gnt]) begin
                cur_d    = gnt + DEST_W'(1);
                credit_d = '0;
            end else begin
                cur_d    = gnt;
                credit_d = credit_new;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cur_q    <= '0;
            credit_q <= '0;
        end else begin
            cur_q    <= cur_d;
            credit_q <= credit_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            push_q <= '0;
            data_q <= '0;
            idle_q <= 1'b1;
        end else if (gnt_vld) begin
            push_q      <= '0;
            push_q[dst[gnt]] <= 1'b1;
            data_q      <= head[gnt];
            idle_q      <= 1'b0;
        end else begin
            push_q <= '0;
            idle_q <= 1'b1;
        end
    end

    assign out_push = push_q;
    assign out_data = data_q;
    assign idle     = idle_q;

endmodule

// File: tb/tb_arbitro_wrr.sv
// Directed bench for arbitro_wrr: FIFO heads come from per-channel counters, expected
// pop order is hand-written per scenario and the output stage is checked one cycle later.
module tb_arbitro_wrr;
    import arbitro_pkg::*;

    localparam int N  = 4;
    localparam int W  = 12;
    localparam int WW = 3;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            mode = 1'b0;
    logic [N*WW-1:0] weights;
    logic [N-1:0]    in_empty;
    logic [N*W-1:0]  in_data;
    logic [N-1:0]    in_pop;
    logic [N-1:0]    out_almost_full;
    logic [N-1:0]    out_push;
    logic [W-1:0]    out_data;
    logic            idle;

    int          cnt [N];
    logic [1:0]  dst [N];
    logic [5:0]  seq [N];

    int          n_cmp = 0;
    int          n_bad = 0;
    string       tname = "init";

    logic [N-1:0] e_push = '0;
    logic [W-1:0] e_data = '0;
    logic         e_idle = 1'b1;

    int o2 [10] = '{0, 1, 1, 2, 2, 2, 3, 3, 3, 3};
    int o3 [8]  = '{0, 2, 2, 2, 3, 3, 3, 3};
    int o4 [7]  = '{0, 1, 1, 3, 3, 3, 3};
    int o5 [10] = '{1, 2, 2, 2, 3, 3, 3, 3, 1, 1};

    arbitro_wrr #(.N_CH(N), .WORD_SIZE(W), .WEIGHT_W(WW)) dut (
        .clk             (clk),
        .reset           (reset),
        .mode            (mode),
        .weights         (weights),
        .in_empty        (in_empty),
        .in_data         (in_data),
        .in_pop          (in_pop),
        .out_almost_full (out_almost_full),
        .out_push        (out_push),
        .out_data        (out_data),
        .idle            (idle)
    );

    always #5 clk = ~clk;

    always_comb begin
        in_data  = '0;
        in_empty = '0;
        for (int i = 0; i < N; i++) begin
            in_data[i*W +: W] = {2'b01, dst[i], 2'(i), seq[i]};
            in_empty[i]       = (cnt[i] == 0);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s.%s @%0t: got %0h expected %0h", tname, tag, $time, got, exp);
        end
    endtask

    // One cycle: check at the falling edge, advance the FIFO model just after the rising edge.
    task automatic cyc(input int ch);
        logic [N-1:0] ep;
        logic [N-1:0] p;
        logic [W-1:0] w;
        @(negedge clk);
        ep = (ch < 0) ? '0 : (N'(1) << ch);
        chk("in_pop",   {28'd0, in_pop},   {28'd0, ep});
        chk("out_push", {28'd0, out_push}, {28'd0, e_push});
        chk("out_data", {20'd0, out_data}, {20'd0, e_data});
        chk("idle",     {31'd0, idle},     {31'd0, e_idle});
        if (!reset) begin
            e_push = '0;
            e_data = '0;
            e_idle = 1'b1;
        end else if (ch >= 0) begin
            w      = {2'b01, dst[ch], 2'(ch), seq[ch]};
            e_push = N'(1) << dst[ch];
            e_data = w;
            e_idle = 1'b0;
            chk("dest_of", {30'd0, dest_of(w)}, {30'd0, dst[ch]});
        end else begin
            e_push = '0;
            e_idle = 1'b1;
        end
        p = in_pop;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
            if (p[i] && cnt[i] > 0) begin
                cnt[i]--;
                seq[i]++;
            end
    endtask

    initial begin
        weights         = {3'd4, 3'd3, 3'd2, 3'd1};
        out_almost_full = '0;
        for (int i = 0; i < N; i++) begin
            cnt[i] = 5;
            dst[i] = 2'(i);
            seq[i] = '0;
        end

        // Pop is gated while reset is low even with loaded FIFOs
        tname = "reset";
        repeat (3) cyc(-1);

        tname = "empty";
        for (int i = 0; i < N; i++) cnt[i] = 0;
        reset = 1'b1;
        repeat (20) cyc(-1);

        tname = "wrr";
        for (int i = 0; i < N; i++) cnt[i] = 200;
        repeat (2) foreach (o2[k]) cyc(o2[k]);

        tname = "blocked";
        dst[0] = 2'd0; dst[1] = 2'd2; dst[2] = 2'd1; dst[3] = 2'd3;
        out_almost_full = 4'b0100;
        repeat (2) foreach (o3[k]) cyc(o3[k]);
        tname = "unblocked";
        out_almost_full = '0;
        foreach (o2[k]) cyc(o2[k]);

        tname = "wzero";
        for (int i = 0; i < N; i++) begin
            dst[i] = 2'(i);
            cnt[i] = 200;
        end
        weights = {3'd4, 3'd0, 3'd2, 3'd1};
        repeat (15) foreach (o4[k]) cyc(o4[k]);

        tname = "strict";
        weights = {3'd4, 3'd3, 3'd2, 3'd1};
        cyc(0);
        cyc(1);
        mode   = 1'b1;
        cnt[0] = 5; cnt[1] = 0; cnt[2] = 0; cnt[3] = 200;
        repeat (5) cyc(0);
        repeat (3) cyc(3);
        tname = "resume";
        mode   = 1'b0;
        cnt[1] = 200; cnt[2] = 200;
        foreach (o5[k]) cyc(o5[k]);

        tname = "midreset";
        cnt[0] = 200;
        cyc(2);
        reset = 1'b0;
        cyc(-1);
        reset = 1'b1;
        cyc(0);
        cyc(1);
        cyc(1);
        cyc(2);
        cyc(-1 + 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
